// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits, sampled mid-bit on tick.
// Word appears 1 clk after the last stop sample and is held under valid/ready; a frame finishing while unaccepted is dropped with an overrun pulse.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_high_q, wait_high_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 frame_done;
  logic                 ferr_fin;

  always_comb begin
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    // After a frame ends on a low line (break), wait for the line to go high before re-arming.
    wait_high_d   = wait_high_q & ~rx_s_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = 1'b0;
    frame_done    = 1'b0;
    ferr_fin      = ferr_q | ~rx_s_q;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q && !wait_high_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              perr_d     = 1'b0;
              ferr_d     = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            perr_d     = (^shift_q) ^ rx_s_q ^ (PARITY_ODD != 0);
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            ferr_d     = ferr_fin;
            if (bit_cnt_q == LAST_STOP) begin
              state_d     = S_IDLE;
              frame_done  = 1'b1;
              wait_high_d = ~rx_s_q;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (frame_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_d;
        parity_err_d = perr_d;
        frame_err_d  = ferr_fin;
        data_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      wait_high_q   <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
      wait_high_q   <= wait_high_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1/OS16 instance and an 8E2/OS8 instance driven with directed and random frames,
// compared against a frame-level model of delivery, flags and overrun.
module tb_uart_rx_os;
  localparam int TDIV = 4;
  localparam int NU   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       rx          [NU];
  logic       data_ready  [NU];
  logic [7:0] data_out    [NU];
  logic       data_valid  [NU];
  logic       parity_err  [NU];
  logic       frame_err   [NU];
  logic       overrun_err [NU];
  logic       busy        [NU];

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rx(rx[0]), .tick(tick), .data_out(data_out[0]),
    .data_valid(data_valid[0]), .data_ready(data_ready[0]), .parity_err(parity_err[0]),
    .frame_err(frame_err[0]), .overrun_err(overrun_err[0]), .busy(busy[0]));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rx(rx[1]), .tick(tick), .data_out(data_out[1]),
    .data_valid(data_valid[1]), .data_ready(data_ready[1]), .parity_err(parity_err[1]),
    .frame_err(frame_err[1]), .overrun_err(overrun_err[1]), .busy(busy[1]));

  function automatic int os_of(input int u);   return (u == 0) ? 16 : 8; endfunction
  function automatic int pen_of(input int u);  return (u == 0) ? 0 : 1;  endfunction
  function automatic int podd_of(input int u); return (u == 0) ? 0 : 0;  endfunction
  function automatic int stop_of(input int u); return (u == 0) ? 1 : 2;  endfunction

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model of the held word per instance
  logic [7:0] m_data  [NU];
  bit         m_valid [NU];
  bit         m_perr  [NU];
  bit         m_ferr  [NU];
  int         m_ovr   [NU];
  int         ovr_seen   [NU];
  int         busy_rises [NU];
  logic       busy_prev  [NU];

  initial forever #5 clk = ~clk;

  int ph = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      ph   = (ph + 1) % TDIV;
      tick = (ph == 0);
    end
  end

  initial begin
    for (int u = 0; u < NU; u++) begin
      ovr_seen[u] = 0; busy_rises[u] = 0; busy_prev[u] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        if (overrun_err[u] === 1'b1) ovr_seen[u] = ovr_seen[u] + 1;
        if (busy[u] === 1'b1 && busy_prev[u] !== 1'b1) busy_rises[u] = busy_rises[u] + 1;
        busy_prev[u] = busy[u];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void reset_model();
    for (int u = 0; u < NU; u++) begin
      m_data[u] = 8'h00; m_valid[u] = 1'b0; m_perr[u] = 1'b0; m_ferr[u] = 1'b0;
    end
  endfunction

  task automatic check_word(input int u, input string tag);
    check_eq($sformatf("%s u%0d valid", tag, u), data_valid[u], m_valid[u]);
    check_eq($sformatf("%s u%0d data", tag, u), data_out[u], m_data[u]);
    check_eq($sformatf("%s u%0d perr", tag, u), parity_err[u], m_perr[u]);
    check_eq($sformatf("%s u%0d ferr", tag, u), frame_err[u], m_ferr[u]);
  endtask

  task automatic idle_bits(input int u, input int nbits);
    repeat (nbits * os_of(u) * TDIV) @(posedge clk);
  endtask

  task automatic accept(input int u);
    @(negedge clk); data_ready[u] = 1'b1;
    @(posedge clk); m_valid[u] = 1'b0;
    @(negedge clk); data_ready[u] = 1'b0;
    check_word(u, "accept");
  endtask

  // Drives one frame; bit j of the frame is sampled by the receiver on tick event 1+OS/2+OS*j after the start edge.
  task automatic send_frame(input int u, input logic [7:0] d, input bit pflip, input logic [1:0] stopv,
                            input bit rdy_done, input int abort_idx, input bit hold_low);
    logic bits[$];
    int   os, n, tc;
    logic pbit;
    bit   ovr_now, mf;
    os   = os_of(u);
    pbit = 1'b0;
    ovr_now = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen_of(u) != 0) begin
      pbit = (^d) ^ (podd_of(u) != 0) ^ pflip;
      bits.push_back(pbit);
    end
    for (int i = 0; i < stop_of(u); i++) bits.push_back(stopv[i]);
    n  = bits.size();
    tc = 1 + os / 2 + os * (n - 1);
    do @(posedge clk); while (tick !== 1'b1);
    for (int k = 1; k <= os * n + 1; k++) begin
      @(negedge clk);
      if (abort_idx >= 0 && k - 1 == os * abort_idx + os / 2) begin
        check_eq($sformatf("busy mid-frame u%0d", u), busy[u], 1'b1);
        reset_n = 1'b0;
        rx[u]   = 1'b1;
        reset_model();
        return;
      end
      if (k - 1 == tc) begin
        data_ready[u] = 1'b0;
        check_word(u, "done");
        check_eq($sformatf("overrun u%0d", u), overrun_err[u], ovr_now);
        check_eq($sformatf("busy after u%0d", u), busy[u], 1'b0);
      end
      if (k - 1 == os * n) begin
        rx[u] = hold_low ? 1'b0 : 1'b1;
        return;
      end
      if ((k - 1) % os == 0) rx[u] = bits[(k - 1) / os];
      repeat (TDIV - 1) @(posedge clk);
      @(negedge clk);
      if (k == tc) begin
        check_eq($sformatf("pre valid u%0d", u), data_valid[u], m_valid[u]);
        check_eq($sformatf("pre busy u%0d", u), busy[u], 1'b1);
        data_ready[u] = rdy_done;
      end
      @(posedge clk);
      if (k == tc) begin
        mf = 1'b0;
        for (int i = 0; i < stop_of(u); i++) if (!stopv[i]) mf = 1'b1;
        if (!m_valid[u] || rdy_done) begin
          m_data[u]  = d;
          m_perr[u]  = (pen_of(u) != 0) && ((($countones(d) + int'(pbit)) % 2) != podd_of(u));
          m_ferr[u]  = mf;
          m_valid[u] = 1'b1;
          ovr_now    = 1'b0;
        end else begin
          ovr_now  = 1'b1;
          m_ovr[u] = m_ovr[u] + 1;
        end
      end
    end
  endtask

  initial begin
    int br, u;
    logic [7:0] d;
    logic [1:0] sv;
    reset_n = 1'b0;
    for (int i = 0; i < NU; i++) begin
      rx[i] = 1'b1; data_ready[i] = 1'b0; m_ovr[i] = 0;
    end
    reset_model();
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      check_word(i, "reset");
      check_eq($sformatf("reset busy u%0d", i), busy[i], 1'b0);
      check_eq($sformatf("reset overrun u%0d", i), overrun_err[i], 1'b0);
    end
    reset_n = 1'b1;
    idle_bits(0, 2);

    // 8N1 word held until accepted
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    idle_bits(0, 3);
    check_word(0, "hold A5");
    accept(0);

    // even parity: wrong then correct parity bit
    send_frame(1, 8'h07, 1'b1, 2'b11, 1'b0, -1, 1'b0);
    accept(1);
    send_frame(1, 8'h07, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    accept(1);

    // 4-tick glitch is a false start
    br = busy_rises[0];
    do @(posedge clk); while (tick !== 1'b1);
    @(negedge clk); rx[0] = 1'b0;
    repeat (4 * TDIV) @(posedge clk);
    @(negedge clk); rx[0] = 1'b1;
    idle_bits(0, 2);
    #1;
    check_eq("glitch busy pulse", busy_rises[0], br + 1);
    check_eq("glitch busy idle", busy[0], 1'b0);
    check_eq("glitch no word", data_valid[0], 1'b0);
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    accept(0);

    // framing errors
    send_frame(0, 8'h55, 1'b0, 2'b10, 1'b0, -1, 1'b0);
    accept(0);
    send_frame(1, 8'h55, 1'b0, 2'b01, 1'b0, -1, 1'b0);
    accept(1);

    // overrun, then simultaneous accept on the completion clock
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    idle_bits(0, 1);
    check_eq("overrun pulses", ovr_seen[0], 1);
    accept(0);
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b1, -1, 1'b0);
    idle_bits(0, 1);
    check_eq("no extra overrun", ovr_seen[0], 1);
    accept(0);

    // break: zero word with framing error, then no restart while the line stays low
    send_frame(0, 8'h00, 1'b0, 2'b00, 1'b0, -1, 1'b1);
    br = busy_rises[0];
    idle_bits(0, 3);
    #1;
    check_eq("break stays idle", busy_rises[0], br);
    check_eq("break busy", busy[0], 1'b0);
    rx[0] = 1'b1;
    idle_bits(0, 2);
    accept(0);

    // reset mid-frame while a word is held
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    send_frame(0, 8'hF0, 1'b0, 2'b11, 1'b0, 4, 1'b0);
    #1;
    check_word(0, "abort");
    check_eq("abort busy", busy[0], 1'b0);
    check_eq("abort valid u1", data_valid[1], 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(0, 2);
    send_frame(0, 8'h81, 1'b0, 2'b11, 1'b0, -1, 1'b0);
    accept(0);

    // random frames on both instances
    for (int i = 0; i < 24; i++) begin
      u  = int'($urandom_range(0, 1));
      d  = 8'($urandom);
      sv = 2'b11;
      if ($urandom_range(0, 4) == 0) sv[$urandom_range(0, stop_of(u) - 1)] = 1'b0;
      if (m_valid[u] && $urandom_range(0, 1) == 1) accept(u);
      send_frame(u, d, ($urandom_range(0, 3) == 0), sv, ($urandom_range(0, 1) == 1), -1, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_bits(u, int'($urandom_range(1, 2)));
    end
    idle_bits(0, 1);
    for (int i = 0; i < NU; i++) begin
      check_eq($sformatf("overrun total u%0d", i), ovr_seen[i], m_ovr[i]);
      check_word(i, "final");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    n_errors++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
